combo_entry: RTL and testbench

COMBO_ENTRY -- requirements
Module: combo_entry

---
 rtl/combo_entry.sv | 158 +++++++++++++++
 tb/tb_combo_entry.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/combo_entry.sv
// -----------------------------------------------------------------------------
// combo_entry
//
// Front end of a combination lock. The raw enable, submit and code switches
// are synchronized. Submit is then debounced. Each debounced press made while
// the entry is armed captures the switch code once. The captured code is
// offered to the lock controller through a valid/ready handshake.
//
// Parameters
//   CODE_W           width of the switch code
//   DEBOUNCE_CYCLES  stable cycles (>= 2) needed before the debounced submit
//                    level follows the synchronized input
//
// Ports
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   en            raw lock-enable switch (asynchronous)
//   submit        raw, bouncing submit button (asynchronous)
//   sw            raw code switches (asynchronous)
//   lockout       synchronous inhibit from the lock controller
//   code_ready    lock controller accepts the code
//   code          captured code
//   code_valid    captured code is waiting for acceptance
//   entry_active  high while armed and waiting for a press
// -----------------------------------------------------------------------------
module combo_entry #(
  parameter int CODE_W          = 6,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              submit,
  input  logic [CODE_W-1:0] sw,
  input  logic              lockout,
  input  logic              code_ready,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              entry_active
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] ARMED        = 2'd1;
  localparam logic [1:0] HOLD         = 2'd2;
  localparam logic [1:0] WAIT_RELEASE = 2'd3;

  logic              en_meta, en_sync;
  logic              sub_meta, sub_sync;
  logic [CODE_W-1:0] sw_meta, sw_sync;

  logic [CNT_W-1:0]  db_cnt;
  logic              db_level;
  logic              db_prev;
  logic              press;
  logic              abort;

  logic [1:0]        state, state_next;
  logic [CODE_W-1:0] code_next;
  logic              valid_next;

  // Two-flop synchronizers for every asynchronous input.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_meta  <= 1'b0;
      en_sync  <= 1'b0;
      sub_meta <= 1'b0;
      sub_sync <= 1'b0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      en_meta  <= en;
      en_sync  <= en_meta;
      sub_meta <= submit;
      sub_sync <= sub_meta;
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
    end
  end

  // Debouncer. The counter counts consecutive cycles of disagreement. The
  // level flips on the edge where the count would reach DEBOUNCE_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
    end else begin
      db_prev <= db_level;
      if (sub_sync != db_level) begin
        if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db_level <= sub_sync;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // A press is the cycle right after the debounced level rises.
  assign press = db_level & ~db_prev;
  assign abort = ~en_sync | lockout;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    code_next  = code;
    valid_next = code_valid;
    case (state)
      IDLE: begin
        if (!abort) state_next = ARMED;
      end
      ARMED: begin
        if (abort) begin
          state_next = IDLE;
        end else if (press) begin
          code_next  = sw_sync;
          valid_next = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        // Only the handshake leaves HOLD; en and lockout are ignored here.
        if (code_valid && code_ready) begin
          valid_next = 1'b0;
          state_next = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        // Wait for the button to come up so one press yields one code.
        if (!db_level) state_next = abort ? IDLE : ARMED;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      code       <= '0;
      code_valid <= 1'b0;
    end else begin
      state      <= state_next;
      code       <= code_next;
      code_valid <= valid_next;
    end
  end

  assign entry_active = (state == ARMED);

endmodule

// File: tb/tb_combo_entry.sv
// -----------------------------------------------------------------------------
// tb_combo_entry
//
// Directed bench for combo_entry with CODE_W=6 and DEBOUNCE_CYCLES=4.
// Inputs change on the falling edge. Outputs are sampled on the falling edge,
// half a period after the rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_combo_entry;

  localparam int CODE_W = 6;
  localparam int DB     = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              submit;
  logic [CODE_W-1:0] sw;
  logic              lockout;
  logic              code_ready;
  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              entry_active;

  int total = 0;
  int bad   = 0;

  combo_entry #(.CODE_W(CODE_W), .DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .submit       (submit),
    .sw           (sw),
    .lockout      (lockout),
    .code_ready   (code_ready),
    .code         (code),
    .code_valid   (code_valid),
    .entry_active (entry_active)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Waits up to max_cyc falling edges for code_valid.
  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (code_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Counts rising edges of code_valid seen over n cycles.
  task automatic count_pulses(input int n, output int pulses);
    logic prev;
    pulses = 0;
    prev   = code_valid;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (code_valid === 1'b1 && prev !== 1'b1) pulses++;
      prev = code_valid;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; submit = 1'b0; sw = '0;
    lockout = 1'b0; code_ready = 1'b0;
    cycles(3);
    total++;
    if (code !== 6'd0 || code_valid !== 1'b0 || entry_active !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: code=%b valid=%b active=%b, need 000000/0/0",
               code, code_valid, entry_active);
    end
    rst_n = 1'b1;
  endtask

  // Submit first sampled at edge k gives valid after k+6; the handshake
  // follows at k+7. The entry then stays in WAIT_RELEASE until release.
  task automatic test_latency;
    en = 1'b1; lockout = 1'b0; code_ready = 1'b1; sw = 6'b101001;
    cycles(3);
    total++;
    if (entry_active !== 1'b1) begin
      bad++;
      $display("FAIL arm_after_en: active=%b, need 1", entry_active);
    end
    submit = 1'b1;
    cycles(6);  // sampled after edge k+5
    total++;
    if (code_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_early: valid=%b after edge k+5, need 0", code_valid);
    end
    cycles(1);  // after edge k+6
    total++;
    if (code_valid !== 1'b1 || code !== 6'b101001) begin
      bad++;
      $display("FAIL latency_capture: valid=%b code=%b, need 1/101001",
               code_valid, code);
    end
    cycles(1);  // after edge k+7
    total++;
    if (code_valid !== 1'b0 || entry_active !== 1'b0) begin
      bad++;
      $display("FAIL handshake_clear: valid=%b active=%b, need 0/0",
               code_valid, entry_active);
    end
    cycles(5);
    total++;
    if (entry_active !== 1'b0 || code !== 6'b101001) begin
      bad++;
      $display("FAIL wait_release_hold: active=%b code=%b, need 0/101001",
               entry_active, code);
    end
    submit = 1'b0;
    cycles(8);
    total++;
    if (entry_active !== 1'b1) begin
      bad++;
      $display("FAIL rearm_after_release: active=%b, need 1", entry_active);
    end
  endtask

  // Bounces of 3, 1 and 2 cycles are all shorter than the debounce window.
  task automatic test_glitch;
    int pulses;
    int widths [3] = '{3, 1, 2};
    int seen = 0;
    code_ready = 1'b1;
    sw = 6'b000111;
    for (int p = 0; p < 3; p++) begin
      submit = 1'b1;
      for (int i = 0; i < widths[p]; i++) begin
        @(negedge clk);
        if (code_valid === 1'b1) seen++;
      end
      submit = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (code_valid === 1'b1) seen++;
      end
    end
    count_pulses(10, pulses);
    total++;
    if (seen + pulses != 0) begin
      bad++;
      $display("FAIL glitch_reject: valid seen %0d times, need 0", seen + pulses);
    end
    total++;
    if (entry_active !== 1'b1) begin
      bad++;
      $display("FAIL glitch_still_armed: active=%b, need 1", entry_active);
    end
  endtask

  // The code must hold while code_ready is low, whatever en, lockout and sw do.
  task automatic test_hold;
    bit ok;
    int viol = 0;
    int pulses;
    code_ready = 1'b0;
    sw = 6'b010110;
    submit = 1'b1;
    wait_valid(20, ok);
    total++;
    if (!ok || code !== 6'b010110) begin
      bad++;
      $display("FAIL hold_capture: ok=%0d code=%b, need 1/010110", ok, code);
    end
    for (int i = 0; i < 20; i++) begin
      en = 1'($urandom_range(0, 1));
      lockout = 1'($urandom_range(0, 1));
      sw = 6'($urandom);
      @(negedge clk);
      if (code_valid !== 1'b1 || code !== 6'b010110) viol++;
    end
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL hold_stable: %0d unstable cycles, need 0", viol);
    end
    en = 1'b1; lockout = 1'b0; sw = 6'b000000; code_ready = 1'b1;
    @(negedge clk);
    total++;
    if (code_valid !== 1'b0 || code !== 6'b010110) begin
      bad++;
      $display("FAIL hold_transfer: valid=%b code=%b, need 0/010110",
               code_valid, code);
    end
    count_pulses(12, pulses);
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL hold_single_transfer: %0d extra pulses, need 0", pulses);
    end
    submit = 1'b0;
    cycles(10);
    total++;
    if (entry_active !== 1'b1) begin
      bad++;
      $display("FAIL hold_rearm: active=%b, need 1", entry_active);
    end
  endtask

  // A long hold yields one code; a fresh press yields another.
  task automatic test_back_to_back;
    int pulses;
    code_ready = 1'b1;
    sw = 6'b111111;
    submit = 1'b1;
    count_pulses(100, pulses);
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL long_hold_one_pulse: %0d pulses, need 1", pulses);
    end
    submit = 1'b0;
    cycles(10);
    submit = 1'b1;
    count_pulses(20, pulses);
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL repress_pulse: %0d pulses, need 1", pulses);
    end
    submit = 1'b0;
    cycles(10);
  endtask

  task automatic test_lockout;
    int pulses;
    bit ok;
    code_ready = 1'b1;
    lockout = 1'b1;
    @(negedge clk);
    total++;
    if (entry_active !== 1'b0) begin
      bad++;
      $display("FAIL lockout_disarm: active=%b, need 0", entry_active);
    end
    submit = 1'b1;
    count_pulses(15, pulses);
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL lockout_no_code: %0d pulses, need 0", pulses);
    end
    submit = 1'b0;
    cycles(10);
    lockout = 1'b0;
    cycles(2);
    total++;
    if (entry_active !== 1'b1) begin
      bad++;
      $display("FAIL lockout_rearm: active=%b, need 1", entry_active);
    end
    code_ready = 1'b0;
    sw = 6'b110011;
    submit = 1'b1;
    wait_valid(20, ok);
    total++;
    if (!ok || code !== 6'b110011) begin
      bad++;
      $display("FAIL lockout_deliver: ok=%0d code=%b, need 1/110011", ok, code);
    end
    code_ready = 1'b1;
    submit = 1'b0;
    cycles(10);
  endtask

  // Asynchronous reset in HOLD drops the code before the next edge; a submit
  // still held after reset is then treated as a new press.
  task automatic test_reset_in_hold;
    bit ok;
    code_ready = 1'b0;
    sw = 6'b111000;
    submit = 1'b1;
    wait_valid(20, ok);
    total++;
    if (!ok || code !== 6'b111000) begin
      bad++;
      $display("FAIL rst_hold_capture: ok=%0d code=%b, need 1/111000", ok, code);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (code_valid !== 1'b0 || code !== 6'd0 || entry_active !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: valid=%b code=%b active=%b, need 0/000000/0",
               code_valid, code, entry_active);
    end
    cycles(2);
    total++;
    if (code_valid !== 1'b0 || entry_active !== 1'b0) begin
      bad++;
      $display("FAIL reset_held: valid=%b active=%b, need 0/0",
               code_valid, entry_active);
    end
    sw = 6'b001100;
    rst_n = 1'b1;
    wait_valid(20, ok);
    total++;
    if (!ok || code !== 6'b001100) begin
      bad++;
      $display("FAIL post_reset_press: ok=%0d code=%b, need 1/001100", ok, code);
    end
    code_ready = 1'b1;
    submit = 1'b0;
    cycles(10);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_hold();
    test_back_to_back();
    test_lockout();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
